// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage (master) and a combinational memory (slave).
interface instr_fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (output imem_addr, input  imem_instr);
  modport slave  (input  imem_addr, output imem_instr);
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage: drives the instruction memory from the PC and fills the IF/ID register.
// Optional feature macro FETCH_COUNT_EN adds a saturating fetch_count_o counter.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  instr_fetch_stage_if.master        imem,
  input  logic                       boot_done_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic                       branch_taken_i,
  input  logic [31:0]                branch_target_i,
  output logic [31:0]                if_pc_o,
  output logic [31:0]                if_instr_o,
  output logic                       if_valid_o,
  output logic                       halted_o,
  output logic                       misalign_o
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]                fetch_count_o
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        halted_q, halted_d;
  logic        misalign_q, misalign_d;
  logic        capture_new;

  logic [31:0] redirect_pc;
  logic        redirect_misalign;

  assign redirect_pc       = {branch_target_i[31:2], 2'b00};
  assign redirect_misalign = |branch_target_i[1:0];

  // NOTE: every always_comb output is given a hold/default value first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = if_valid_q;
    halted_d    = halted_q;
    misalign_d  = 1'b0;
    capture_new = 1'b0;

    unique case (state_q)
      BOOT: begin
        if_valid_d = 1'b0;
        if (boot_done_i) state_d = RUN;
      end
      RUN: begin
        if (branch_taken_i) begin
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
          misalign_d = redirect_misalign;
        end else if (stall_i) begin
          if (flush_i) if_valid_d = 1'b0;
        end else if (imem.imem_instr == 32'h0 || pc_q >= PC_LIMIT) begin
          // A zero word is unloaded or terminator memory; past the end nothing valid can be read.
          state_d    = HALT;
          halted_d   = 1'b1;
          if_valid_d = 1'b0;
        end else begin
          if_pc_d     = pc_q;
          if_instr_d  = imem.imem_instr;
          if_valid_d  = !flush_i;
          capture_new = !flush_i;
          pc_d        = pc_q + 32'd4;
        end
      end
      HALT: begin
        if_valid_d = 1'b0;
        // A branch resolved after the halt restarts fetch at its target.
        if (branch_taken_i) begin
          pc_d       = redirect_pc;
          misalign_d = redirect_misalign;
          state_d    = RUN;
          halted_d   = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (capture_new && fetch_count_q != 32'hFFFF_FFFF) fetch_count_d = fetch_count_q + 32'd1;
  end

  assign fetch_count_o = fetch_count_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_pc_q       <= 32'h0;
      if_instr_q    <= 32'h0;
      if_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      misalign_q    <= 1'b0;
`ifdef FETCH_COUNT_EN
      fetch_count_q <= 32'h0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      if_valid_q    <= if_valid_d;
      halted_q      <= halted_d;
      misalign_q    <= misalign_d;
`ifdef FETCH_COUNT_EN
      fetch_count_q <= fetch_count_d;
`endif
    end
  end

  assign imem.imem_addr = pc_q;
  assign if_pc_o        = if_pc_q;
  assign if_instr_o     = if_instr_q;
  assign if_valid_o     = if_valid_q;
  assign halted_o       = halted_q;
  assign misalign_o     = misalign_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: boot gating, sequential fetch, stall/flush, redirect, halt, async reset.
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset;
  logic        boot_done_i;
  logic        stall_i;
  logic        flush_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_valid_o;
  logic        halted_o;
  logic        misalign_o;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_o;
`endif

  logic [31:0] mem [64];
  int          n_checks;
  int          n_fail;

  instr_fetch_stage_if bus ();

  // Unmapped addresses return a nonzero pattern so only the range check can stop fetch there.
  assign bus.imem_instr = (bus.imem_addr < 32'd256) ? mem[bus.imem_addr[7:2]] : 32'hDEAD_BEEF;

  instr_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (bus.master),
    .boot_done_i    (boot_done_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .if_pc_o        (if_pc_o),
    .if_instr_o     (if_instr_o),
    .if_valid_o     (if_valid_o),
    .halted_o       (halted_o),
    .misalign_o     (misalign_o)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count_o  (fetch_count_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},     bus.imem_addr, 32'h0);
    check({tag, "_if_pc"},    if_pc_o, 32'h0);
    check({tag, "_if_instr"}, if_instr_o, 32'h0);
    check({tag, "_valid"},    {31'h0, if_valid_o}, 32'h0);
    check({tag, "_halted"},   {31'h0, halted_o}, 32'h0);
    check({tag, "_misalign"}, {31'h0, misalign_o}, 32'h0);
`ifdef FETCH_COUNT_EN
    check({tag, "_count"},    fetch_count_o, 32'h0);
`endif
  endtask

  task automatic capture_check(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    check({tag, "_if_pc"},    if_pc_o, exp_pc);
    check({tag, "_if_instr"}, if_instr_o, exp_instr);
    check({tag, "_valid"},    {31'h0, if_valid_o}, 32'h1);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    boot_done_i     = 1'b0;
    stall_i         = 1'b0;
    flush_i         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0000_1111;
    mem[2] = 32'h0000_2222;
    mem[3] = 32'h0;
    for (int i = 4; i < 10; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[10] = 32'h0;

    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    #2 reset = 1'b1;

    // Boot gating: nothing fetched while boot_done_i is low.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("boot_addr", bus.imem_addr, 32'h0);
      check("boot_valid", {31'h0, if_valid_o}, 32'h0);
    end
    boot_done_i = 1'b1;
    tick();
    boot_done_i = 1'b0;
    check("boot_edge1_valid", {31'h0, if_valid_o}, 32'h0);
    tick();
    capture_check("first", 32'h0, 32'h0050_0093);
    check("first_pc", bus.imem_addr, 32'h4);

    // Sequential fetch then halt on the zero word at 12.
    tick();
    capture_check("seq4", 32'h4, 32'h0000_1111);
    tick();
    capture_check("seq8", 32'h8, 32'h0000_2222);
    check("seq8_pc", bus.imem_addr, 32'hC);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_flag", {31'h0, halted_o}, 32'h1);
      check("halt_pc", bus.imem_addr, 32'hC);
      check("halt_valid", {31'h0, if_valid_o}, 32'h0);
    end
`ifdef FETCH_COUNT_EN
    check("count_after_halt", fetch_count_o, 32'd3);
`endif

    // Halt exit: branch to 0x10 resumes fetch there.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h10;
    tick();
    branch_taken_i  = 1'b0;
    check("hexit_halted", {31'h0, halted_o}, 32'h0);
    check("hexit_pc", bus.imem_addr, 32'h10);
    check("hexit_valid", {31'h0, if_valid_o}, 32'h0);
    check("hexit_misalign", {31'h0, misalign_o}, 32'h0);
    tick();
    capture_check("hexit_cap", 32'h10, 32'hA000_0004);

    // Rewind to 0 and run until pc=8 with if_pc=4.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0;
    tick();
    branch_taken_i  = 1'b0;
    check("rew_valid", {31'h0, if_valid_o}, 32'h0);
    tick();
    tick();
    capture_check("pre_stall", 32'h4, 32'h0000_1111);

    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.imem_addr, 32'h8);
      capture_check("stall_hold", 32'h4, 32'h0000_1111);
    end
    stall_i = 1'b0;

    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_valid", {31'h0, if_valid_o}, 32'h0);
    check("flush_pc", bus.imem_addr, 32'hC);

    // Redirect with a misaligned target overrides a simultaneous stall.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h22;
    stall_i         = 1'b1;
    tick();
    branch_taken_i  = 1'b0;
    stall_i         = 1'b0;
    check("br_pc", bus.imem_addr, 32'h20);
    check("br_misalign", {31'h0, misalign_o}, 32'h1);
    check("br_valid", {31'h0, if_valid_o}, 32'h0);
    tick();
    check("br_misalign_drop", {31'h0, misalign_o}, 32'h0);
    capture_check("br_cap", 32'h20, 32'hA000_0008);

    // Stall together with flush: PC and IF/ID data hold but the valid bit clears.
    stall_i = 1'b1;
    flush_i = 1'b1;
    tick();
    stall_i = 1'b0;
    flush_i = 1'b0;
    check("sf_pc", bus.imem_addr, 32'h24);
    check("sf_if_pc", if_pc_o, 32'h20);
    check("sf_valid", {31'h0, if_valid_o}, 32'h0);
    tick();
    capture_check("sf_cap", 32'h24, 32'hA000_0009);
    tick();
    check("halt2_flag", {31'h0, halted_o}, 32'h1);
    check("halt2_pc", bus.imem_addr, 32'h28);

    // Async reset between edges while running at pc=0x14.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h10;
    tick();
    branch_taken_i  = 1'b0;
    tick();
    check("pre_rst_pc", bus.imem_addr, 32'h14);
    #3 reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_addr", bus.imem_addr, 32'h0);
      check("post_rst_valid", {31'h0, if_valid_o}, 32'h0);
    end

    // Range limit: with every word nonzero, fetch stops at pc=256.
    for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 + 32'(i);
    boot_done_i = 1'b1;
    tick();
    boot_done_i = 1'b0;
    for (int i = 0; i < 64; i++) tick();
    capture_check("range_last", 32'd252, 32'hC000_003F);
    check("range_last_pc", bus.imem_addr, 32'd256);
`ifdef FETCH_COUNT_EN
    check("range_count", fetch_count_o, 32'd64);
`endif
    tick();
    check("range_halted", {31'h0, halted_o}, 32'h1);
    check("range_pc", bus.imem_addr, 32'd256);
    check("range_valid", {31'h0, if_valid_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
